// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - signal bundle between N CPU master ports, the arbiter and the shared slave
interface wb_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0]    m_stb_i;
  logic [N_MASTERS-1:0]    m_we_i;
  logic [N_MASTERS*AW-1:0] m_addr_i;
  logic [N_MASTERS*DW-1:0] m_data_i;
  logic [DW-1:0]           m_data_o;
  logic [N_MASTERS-1:0]    m_ack_o;
  logic [N_MASTERS-1:0]    m_err_o;
  logic                    s_stb_o;
  logic                    s_we_o;
  logic [AW-1:0]           s_addr_o;
  logic [DW-1:0]           s_data_o;
  logic [DW-1:0]           s_data_i;
  logic                    s_ack_i;
  logic [GW-1:0]           grant_o;

  // Arbiter view: it is the slave of the CPU masters and drives the memory side.
  modport slave (
    input  m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_stb_o, s_we_o, s_addr_o, s_data_o, grant_o
  );

  modport master (
    output m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_stb_o, s_we_o, s_addr_o, s_data_o, grant_o
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - N-master Wishbone-style arbiter with fixed/round-robin grant and ack timeout
module wb_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  wb_bus_arbiter_if.slave bus
);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] G_LAST   = GW'(N_MASTERS - 1);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt, rr_ptr, rr_nxt, winner;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy, stb_g, ack_g, err_g;

  // Descending scans so the highest-priority candidate is the last one written.
  always_comb begin
    winner = '0;
    if (ARB_MODE == 0) begin
      for (int i = N_MASTERS - 1; i >= 0; i--)
        if (bus.m_stb_i[i]) winner = GW'(i);
    end else begin
      for (int k = N_MASTERS - 1; k >= 0; k--)
        if (bus.m_stb_i[(int'(rr_ptr) + k) % N_MASTERS])
          winner = GW'((int'(rr_ptr) + k) % N_MASTERS);
    end
  end

  assign busy  = (state == BUSY);
  assign stb_g = bus.m_stb_i[grant];
  assign ack_g = busy & stb_g & bus.s_ack_i;
  assign err_g = TO_EN & busy & stb_g & ~bus.s_ack_i & (cnt == CNT_LAST);

  always_comb begin
    bus.m_ack_o        = '0;
    bus.m_err_o        = '0;
    bus.m_ack_o[grant] = ack_g;
    bus.m_err_o[grant] = err_g;
  end

  assign bus.s_stb_o  = busy & stb_g & ~err_g;
  assign bus.s_we_o   = busy & stb_g & bus.m_we_i[grant];
  assign bus.s_addr_o = bus.m_addr_i[int'(grant)*AW +: AW];
  assign bus.s_data_o = bus.m_data_i[int'(grant)*DW +: DW];
  assign bus.m_data_o = bus.s_data_i;
  assign bus.grant_o  = grant;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|bus.m_stb_i) begin
          state_nxt = BUSY;
          grant_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        // Ack beats a timeout landing in the same cycle; only an ack moves the pointer.
        if (ack_g) begin
          state_nxt = IDLE;
          rr_nxt    = (grant == G_LAST) ? '0 : grant + 1'b1;
        end else if (!stb_g || err_g) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - bench for wb_bus_arbiter: 2-master fixed priority and 4-master round-robin
module tb_wb_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  stb [2];
  logic [3:0]  we [2];
  logic [31:0] addr [2][4];
  logic [31:0] wdat [2][4];
  logic [31:0] sdat [2];
  logic        sack [2];

  int tests = 0;
  int fails = 0;

  wb_bus_arbiter_if #(.N_MASTERS(2), .AW(32), .DW(32)) bus0 ();
  wb_bus_arbiter_if #(.N_MASTERS(4), .AW(32), .DW(32)) bus1 ();

  wb_bus_arbiter #(.N_MASTERS(2), .AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT(TO)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .bus(bus0));
  wb_bus_arbiter #(.N_MASTERS(4), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT(TO)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .bus(bus1));

  assign bus0.m_stb_i  = stb[0][1:0];
  assign bus0.m_we_i   = we[0][1:0];
  assign bus0.m_addr_i = {addr[0][1], addr[0][0]};
  assign bus0.m_data_i = {wdat[0][1], wdat[0][0]};
  assign bus0.s_data_i = sdat[0];
  assign bus0.s_ack_i  = sack[0];
  assign bus1.m_stb_i  = stb[1];
  assign bus1.m_we_i   = we[1];
  assign bus1.m_addr_i = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
  assign bus1.m_data_i = {wdat[1][3], wdat[1][2], wdat[1][1], wdat[1][0]};
  assign bus1.s_data_i = sdat[1];
  assign bus1.s_ack_i  = sack[1];

  logic [3:0]  a_ack [2];
  logic [3:0]  a_err [2];
  logic        a_stb [2];
  logic        a_we [2];
  logic [31:0] a_addr [2];
  logic [31:0] a_wd [2];
  logic [31:0] a_rd [2];
  logic [1:0]  a_gnt [2];

  assign a_ack[0]  = {2'b00, bus0.m_ack_o};
  assign a_err[0]  = {2'b00, bus0.m_err_o};
  assign a_stb[0]  = bus0.s_stb_o;
  assign a_we[0]   = bus0.s_we_o;
  assign a_addr[0] = bus0.s_addr_o;
  assign a_wd[0]   = bus0.s_data_o;
  assign a_rd[0]   = bus0.m_data_o;
  assign a_gnt[0]  = {1'b0, bus0.grant_o};
  assign a_ack[1]  = bus1.m_ack_o;
  assign a_err[1]  = bus1.m_err_o;
  assign a_stb[1]  = bus1.s_stb_o;
  assign a_we[1]   = bus1.s_we_o;
  assign a_addr[1] = bus1.s_addr_o;
  assign a_wd[1]   = bus1.s_data_o;
  assign a_rd[1]   = bus1.m_data_o;
  assign a_gnt[1]  = bus1.grant_o;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus (-1 = nobody), how long it has waited, rr pointer.
  int own [2]  = '{-1, -1};
  int age [2]  = '{0, 0};
  int rr [2]   = '{0, 0};
  int gnt [2]  = '{0, 0};
  int m_w, m_i, m_g;

  function automatic int nm(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        own[d] = -1; age[d] = 0; rr[d] = 0; gnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (own[d] < 0) begin
          m_w = -1;
          for (int k = 0; k < nm(d); k++) begin
            m_i = (d == 0) ? k : (rr[d] + k) % nm(d);
            if (m_w < 0 && stb[d][m_i]) m_w = m_i;
          end
          if (m_w >= 0) begin
            own[d] = m_w; gnt[d] = m_w; age[d] = 0;
          end
        end else begin
          m_g = own[d];
          if (!stb[d][m_g]) own[d] = -1;
          else if (sack[d]) begin
            rr[d] = (m_g + 1) % nm(d);
            own[d] = -1;
          end else if (age[d] == TO - 1) own[d] = -1;
          else age[d]++;
        end
      end
    end
  end

  logic [3:0] e_ack, e_err;
  logic       e_stb, e_we;
  int         c_g;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_ack = '0; e_err = '0; e_stb = 1'b0; e_we = 1'b0;
      if (own[d] >= 0) begin
        c_g = own[d];
        if (stb[d][c_g]) begin
          if (sack[d]) e_ack[c_g] = 1'b1;
          else if (age[d] == TO - 1) e_err[c_g] = 1'b1;
          e_stb = ~e_err[c_g];
          e_we  = we[d][c_g];
        end
      end
      check("m_ack_o", d, 32'(a_ack[d]), 32'(e_ack));
      check("m_err_o", d, 32'(a_err[d]), 32'(e_err));
      check("s_stb_o", d, 32'(a_stb[d]), 32'(e_stb));
      check("s_we_o", d, 32'(a_we[d]), 32'(e_we));
      check("s_addr_o", d, a_addr[d], addr[d][gnt[d]]);
      check("s_data_o", d, a_wd[d], wdat[d][gnt[d]]);
      check("m_data_o", d, a_rd[d], sdat[d]);
      check("grant_o", d, 32'(a_gnt[d]), 32'(gnt[d]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int d = 0; d < 2; d++) begin
      stb[d] = '0; we[d] = '0; sdat[d] = '0; sack[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        addr[d][k] = 32'h1000 * (d + 1) + 32'h10 * k;
        wdat[d][k] = 32'hA000_0000 + 32'h100 * d + k;
      end
    end
    cyc(); cyc();
    settle();
    check("reset_stb", 0, 32'(a_stb[0]), 32'd0);
    check("reset_grant", 1, 32'(a_gnt[1]), 32'd0);
    rst = 1'b1;

    // Single read, master 1, acked in 3rd BUSY cycle.
    cyc();
    stb[0] = 4'b0010; addr[0][1] = 32'h0000_0100;
    settle(); check("t1_idle_stb", 0, 32'(a_stb[0]), 32'd0);
    cyc(); settle();
    check("t1_stb_rise", 0, 32'(a_stb[0]), 32'd1);
    check("t1_grant", 0, 32'(a_gnt[0]), 32'd1);
    check("t1_addr", 0, a_addr[0], 32'h0000_0100);
    cyc(); cyc();
    sack[0] = 1'b1; sdat[0] = 32'hDEAD_BEEF;
    settle();
    check("t1_ack", 0, 32'(a_ack[0]), 32'b10);
    check("t1_rdata", 0, a_rd[0], 32'hDEAD_BEEF);
    cyc();
    stb[0] = '0; sack[0] = 1'b0;
    settle(); check("t1_stb_fall", 0, 32'(a_stb[0]), 32'd0);

    // Fixed priority: master 0 always wins, then master 1 once 0 lets go.
    stb[0] = 4'b0011; sack[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc(); settle();
      check("t2_grant", 0, 32'(a_gnt[0]), 32'd0);
      check("t2_ack", 0, 32'(a_ack[0]), 32'b01);
      cyc();
    end
    stb[0] = 4'b0010;
    cyc(); settle();
    check("t2_m1_grant", 0, 32'(a_gnt[0]), 32'd1);
    check("t2_m1_ack", 0, 32'(a_ack[0]), 32'b10);
    cyc();
    stb[0] = '0; sack[0] = 1'b0;

    // Timeout on a master 0 write with no slave ack.
    cyc();
    stb[0] = 4'b0001; we[0] = 4'b0001; addr[0][0] = 32'h40;
    cyc(); cyc(); cyc(); cyc();
    settle();
    check("t4_err", 0, 32'(a_err[0]), 32'b01);
    check("t4_stb_forced", 0, 32'(a_stb[0]), 32'd0);
    check("t4_no_ack", 0, 32'(a_ack[0]), 32'd0);
    cyc(); settle();
    check("t4_idle", 0, 32'(a_stb[0]), 32'd0);
    stb[0] = '0; we[0] = '0;
    cyc();

    // Ack in the cycle the timeout would fire: ack wins.
    stb[0] = 4'b0001;
    cyc(); cyc(); cyc(); cyc();
    sack[0] = 1'b1;
    settle();
    check("t4b_ack", 0, 32'(a_ack[0]), 32'b01);
    check("t4b_no_err", 0, 32'(a_err[0]), 32'd0);
    cyc();
    stb[0] = '0; sack[0] = 1'b0;

    // Abort: master 1 drops stb in the 2nd BUSY cycle; a stray ack is ignored.
    stb[0] = 4'b0010;
    cyc(); settle(); check("t5_b1_stb", 0, 32'(a_stb[0]), 32'd1);
    cyc();
    stb[0] = '0; sack[0] = 1'b1;
    settle();
    check("t5_stb", 0, 32'(a_stb[0]), 32'd0);
    check("t5_ack", 0, 32'(a_ack[0]), 32'd0);
    check("t5_err", 0, 32'(a_err[0]), 32'd0);
    cyc(); sack[0] = 1'b0;
    settle(); check("t5_idle", 0, 32'(a_stb[0]), 32'd0);

    // Reset in the middle of a transfer.
    stb[0] = 4'b0010;
    cyc(); settle();
    check("t6_busy_stb", 0, 32'(a_stb[0]), 32'd1);
    check("t6_busy_grant", 0, 32'(a_gnt[0]), 32'd1);
    sack[0] = 1'b1; #1;
    check("t6_pre_ack", 0, 32'(a_ack[0]), 32'b10);
    rst = 1'b0; #1;
    check("t6_rst_stb", 0, 32'(a_stb[0]), 32'd0);
    check("t6_rst_ack", 0, 32'(a_ack[0]), 32'd0);
    check("t6_rst_err", 0, 32'(a_err[0]), 32'd0);
    check("t6_rst_grant", 0, 32'(a_gnt[0]), 32'd0);
    sack[0] = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    settle(); check("t6_post_idle", 0, 32'(a_stb[0]), 32'd0);
    cyc(); settle();
    check("t6_regrant_stb", 0, 32'(a_stb[0]), 32'd1);
    check("t6_regrant", 0, 32'(a_gnt[0]), 32'd1);
    sack[0] = 1'b1;
    cyc();
    stb[0] = '0; sack[0] = 1'b0;

    // Round-robin over four masters.
    stb[1] = 4'b1111; sack[1] = 1'b1; sdat[1] = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      cyc(); settle();
      check("t3_grant", 1, 32'(a_gnt[1]), 32'(exp_rr[k]));
      check("t3_stb", 1, 32'(a_stb[1]), 32'd1);
      cyc(); settle();
      check("t3_idle", 1, 32'(a_stb[1]), 32'd0);
    end
    stb[1] = '0; sack[1] = 1'b0;
    cyc();

    // Timeout on master 1 must not advance the pointer (still 1).
    stb[1] = 4'b0010;
    cyc(); cyc(); cyc(); cyc();
    settle();
    check("t4c_err", 1, 32'(a_err[1]), 32'b0010);
    cyc();
    stb[1] = 4'b0111;
    cyc(); settle();
    check("t4c_rr_grant", 1, 32'(a_gnt[1]), 32'd1);
    sack[1] = 1'b1;
    cyc();
    stb[1] = '0; sack[1] = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
